reg_rename: RTL and testbench
=============================

# reg_rename

Register-rename stage between the decoder and the physical register file. It maps architectural source and destination registers (32) onto physical registers (64), allocates destinations from a free list, and owns the busy bits. Writeback clears busy bits, and retirement returns the destination's previous mapping to the free list. It produces the physical indices and busy vector the register file reads from and writes to.

## Interface
- ARCH_REGS, 32, architectural register count (index width 5)
- PHYS_REGS, 64, physical register count (index width 6)
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- i_valid  in  1  decoded instruction present
- i_uses_rs / i_uses_rt / i_uses_rw  in  1 each  operand-use flags from the decoder
- i_rs_addr / i_rt_addr / i_rw_addr  in  5 each  architectural indices
- i_stall  in  1  downstream hold
- o_ready  out  1  instruction accepted this cycle when i_valid is high
- o_valid  out  1  registered rename result valid
- o_uses_rs / o_uses_rt / o_uses_rw  out  1 each  registered copies of the use flags
- o_rs_phys / o_rt_phys / o_rw_phys  out  6 each  physical indices
- o_old_rw_phys  out  6  previous mapping of rw, carried to retire
- o_busy_bits  out  64  busy bit per physical register
- i_wb_valid  in  1  writeback to a physical register
- i_wb_phys  in  6  physical register written back
- i_retire_valid  in  1  instruction retired
- i_retire_old_phys  in  6  physical register to free
- o_free_count  out  7  number of free-list entries

## Operation
- Reset values:
  - map[i] = i for all i.
  - Free list holds 32..63 in ascending order; o_free_count = 32.
  - busy = 0.
  - o_valid = 0; all other outputs are 0.
- Register 0 handling:
  - Arch reg 0 is never renamed. i_uses_rw with i_rw_addr = 0 is treated as no destination.
  - A source reading reg 0 maps to phys 0.
- o_ready = !i_stall && (o_free_count != 0 || !effective_uses_rw).
- Accept = i_valid && o_ready. On accept:
  - Sources are looked up in the map **before** this cycle's update, so rs == rw reads the old mapping.
  - If rw is used: pop the free-list head to get new_phys; o_old_rw_phys = map[rw]; map[rw] = new_phys; busy[new_phys] = 1.
- Output holding:
  - i_stall high: all o_* rename outputs hold.
  - Not stalled and not accepted: o_valid = 0.
- Writeback: i_wb_valid clears busy[i_wb_phys].
  - Same-cycle set and clear of the same index: set wins.
  - Writeback to phys 0 is ignored.
- Retire: i_retire_valid pushes i_retire_old_phys to the free-list tail.
  - Phys 0 is never pushed.
  - A push with count == PHYS_REGS-1 is dropped and flagged by a simulation assertion.
- Simultaneous pop and push: count is unchanged. An entry pushed in a cycle is not poppable until the next cycle.
- Free-list pointers are 6-bit and wrap modulo 64.
- Empty free list with a pending destination: o_ready = 0 and the map is unchanged.

## Timing
- Rename latency is 1 cycle: the instruction is accepted at edge N and its outputs are valid after edge N.
- Map, busy, and free-list updates take effect at the accepting edge. A back-to-back dependent instruction sees the new mapping.
- o_ready and o_free_count are functions of registered state plus current inputs. There is no combinational path from i_wb_* or i_retire_* to o_ready.
- rst asserted mid-operation immediately restores every reset value. In-flight allocations are lost.

## Configuration
- Macro: RENAME_WB_BYPASS_EN.
- Defined: o_busy_bits = busy_q & ~onehot(i_wb_phys when i_wb_valid). A same-cycle writeback is visible combinationally.
- Undefined: o_busy_bits = busy_q. The clear becomes visible one cycle later.

## Structure
- Shared package reg_rename_pkg contains:
  - typedef arch_reg_t (5 bits), phys_reg_t (6 bits).
  - Constants ARCH_REGS, PHYS_REGS.
- Sub-module reg_free_list: circular FIFO with 64 entries of phys_reg_t, head/tail pointers, count, push/pop ports, and reset preload of 32..63.
- The map table and busy vector are flops inside reg_rename.

## Test plan
- Reset, then rename rs=3, rt=4, rw=5 → o_rs_phys=3, o_rt_phys=4, o_rw_phys=32, o_old_rw_phys=5, busy[32]=1, o_free_count=31.
- Two back-to-back instructions, both rw=5, the second reading rs=5 → second o_rs_phys=32, o_rw_phys=33, o_old_rw_phys=32.
- Allocate 32 destinations with no retire → o_free_count=0. The next instruction using rw gets o_ready=0. An instruction without rw is still accepted.
- With free list empty, retire old_phys=5 → o_ready=1 the next cycle and allocation returns 5.
- Writeback of phys 32 while busy[32]=1 → with RENAME_WB_BYPASS_EN, o_busy_bits[32]=0 the same cycle; without it, 0 one cycle later.
- Assert rst during a stall with 10 allocations outstanding → map is identity, o_free_count=32, busy=0, and o_valid=0 immediately.

Source files
------------

// File: rtl/reg_rename_pkg.sv
// Shared types and sizes for the register-rename stage.
package reg_rename_pkg;
    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;
    localparam int ARCH_W    = $clog2(ARCH_REGS);
    localparam int PHYS_W    = $clog2(PHYS_REGS);

    typedef logic [ARCH_W-1:0] arch_reg_t;
    typedef logic [PHYS_W-1:0] phys_reg_t;
    typedef logic [PHYS_W:0]   count_t;
endpackage

// File: rtl/reg_free_list.sv
// Circular FIFO of free physical registers; reset preloads ARCH_REGS..PHYS_REGS-1.
module reg_free_list
    import reg_rename_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  phys_reg_t push_phys,
    input  logic      pop,
    output phys_reg_t pop_phys,
    output count_t    count
);
    phys_reg_t mem_q [PHYS_REGS];
    phys_reg_t mem_d [PHYS_REGS];
    phys_reg_t head_q, head_d;
    phys_reg_t tail_q, tail_d;
    count_t    count_q, count_d;
    logic      do_push, do_pop;

    always_comb begin
        do_pop  = pop && (count_q != '0);
        do_push = push && (count_q != count_t'(PHYS_REGS - 1));
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        // Pop reads only registered state, so a same-cycle push is never handed out.
        if (do_push) begin
            mem_d[tail_q] = push_phys;
            tail_d        = tail_q + 1'b1;
        end
        if (do_pop) begin
            head_d = head_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHYS_REGS; i++) begin
                mem_q[i] <= (i < ARCH_REGS) ? phys_reg_t'(i + ARCH_REGS) : '0;
            end
            head_q  <= '0;
            tail_q  <= phys_reg_t'(ARCH_REGS);
            count_q <= count_t'(PHYS_REGS - ARCH_REGS);
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign pop_phys = mem_q[head_q];
    assign count    = count_q;

    overflow_push_a: assert property (@(posedge clk) disable iff (rst)
        !(push && (count_q == count_t'(PHYS_REGS - 1))))
        else $error("free list full, push of phys %0d dropped", push_phys);
endmodule

// File: rtl/reg_rename.sv
// Register rename: map table, busy bits and free-list allocation/retire.
// Optional macro RENAME_WB_BYPASS_EN exposes a same-cycle writeback clear on o_busy_bits.
module reg_rename
    import reg_rename_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic                 i_uses_rs,
    input  logic                 i_uses_rt,
    input  logic                 i_uses_rw,
    input  arch_reg_t            i_rs_addr,
    input  arch_reg_t            i_rt_addr,
    input  arch_reg_t            i_rw_addr,
    input  logic                 i_stall,
    output logic                 o_ready,
    output logic                 o_valid,
    output logic                 o_uses_rs,
    output logic                 o_uses_rt,
    output logic                 o_uses_rw,
    output phys_reg_t            o_rs_phys,
    output phys_reg_t            o_rt_phys,
    output phys_reg_t            o_rw_phys,
    output phys_reg_t            o_old_rw_phys,
    output logic [PHYS_REGS-1:0] o_busy_bits,
    input  logic                 i_wb_valid,
    input  phys_reg_t            i_wb_phys,
    input  logic                 i_retire_valid,
    input  phys_reg_t            i_retire_old_phys,
    output count_t               o_free_count
);
    phys_reg_t            map_q [ARCH_REGS];
    phys_reg_t            map_d [ARCH_REGS];
    logic [PHYS_REGS-1:0] busy_q, busy_d, wb_clear;

    logic      valid_q, valid_d;
    logic      uses_rs_q, uses_rs_d, uses_rt_q, uses_rt_d, uses_rw_q, uses_rw_d;
    phys_reg_t rs_phys_q, rs_phys_d, rt_phys_q, rt_phys_d;
    phys_reg_t rw_phys_q, rw_phys_d, old_rw_phys_q, old_rw_phys_d;

    logic      eff_rw, accept, alloc, fl_push;
    phys_reg_t new_phys;
    count_t    free_count;

    reg_free_list u_free_list (
        .clk       (clk),
        .rst       (rst),
        .push      (fl_push),
        .push_phys (i_retire_old_phys),
        .pop       (alloc),
        .pop_phys  (new_phys),
        .count     (free_count)
    );

    // Arch reg 0 is hardwired, so a write to it allocates nothing.
    assign eff_rw  = i_uses_rw && (i_rw_addr != '0);
    assign o_ready = !i_stall && ((free_count != '0) || !eff_rw);
    assign accept  = i_valid && o_ready;
    assign alloc   = accept && eff_rw;
    assign fl_push = i_retire_valid && (i_retire_old_phys != '0);

    always_comb begin
        wb_clear = '0;
        if (i_wb_valid && (i_wb_phys != '0)) begin
            wb_clear[i_wb_phys] = 1'b1;
        end
    end

    // Clear first, then set, so an allocation wins over a same-cycle writeback.
    always_comb begin
        map_d  = map_q;
        busy_d = busy_q & ~wb_clear;
        if (alloc) begin
            map_d[i_rw_addr] = new_phys;
            busy_d[new_phys] = 1'b1;
        end
    end

    always_comb begin
        valid_d       = valid_q;
        uses_rs_d     = uses_rs_q;
        uses_rt_d     = uses_rt_q;
        uses_rw_d     = uses_rw_q;
        rs_phys_d     = rs_phys_q;
        rt_phys_d     = rt_phys_q;
        rw_phys_d     = rw_phys_q;
        old_rw_phys_d = old_rw_phys_q;
        if (!i_stall) begin
            valid_d = accept;
            if (accept) begin
                uses_rs_d     = i_uses_rs;
                uses_rt_d     = i_uses_rt;
                uses_rw_d     = eff_rw;
                rs_phys_d     = map_q[i_rs_addr];
                rt_phys_d     = map_q[i_rt_addr];
                rw_phys_d     = eff_rw ? new_phys : '0;
                old_rw_phys_d = eff_rw ? map_q[i_rw_addr] : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_q[i] <= phys_reg_t'(i);
            end
            busy_q        <= '0;
            valid_q       <= 1'b0;
            uses_rs_q     <= 1'b0;
            uses_rt_q     <= 1'b0;
            uses_rw_q     <= 1'b0;
            rs_phys_q     <= '0;
            rt_phys_q     <= '0;
            rw_phys_q     <= '0;
            old_rw_phys_q <= '0;
        end else begin
            map_q         <= map_d;
            busy_q        <= busy_d;
            valid_q       <= valid_d;
            uses_rs_q     <= uses_rs_d;
            uses_rt_q     <= uses_rt_d;
            uses_rw_q     <= uses_rw_d;
            rs_phys_q     <= rs_phys_d;
            rt_phys_q     <= rt_phys_d;
            rw_phys_q     <= rw_phys_d;
            old_rw_phys_q <= old_rw_phys_d;
        end
    end

    assign o_valid       = valid_q;
    assign o_uses_rs     = uses_rs_q;
    assign o_uses_rt     = uses_rt_q;
    assign o_uses_rw     = uses_rw_q;
    assign o_rs_phys     = rs_phys_q;
    assign o_rt_phys     = rt_phys_q;
    assign o_rw_phys     = rw_phys_q;
    assign o_old_rw_phys = old_rw_phys_q;
    assign o_free_count  = free_count;

`ifdef RENAME_WB_BYPASS_EN
    assign o_busy_bits = busy_q & ~wb_clear;
`else
    assign o_busy_bits = busy_q;
`endif
endmodule

// File: tb/tb_reg_rename.sv
// Randomized bench for reg_rename against a queue/array reference model.
module tb_reg_rename;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid, uses_rs, uses_rt, uses_rw, stall;
    logic [4:0]  rs_addr, rt_addr, rw_addr;
    logic        wb_valid, retire_valid;
    logic [5:0]  wb_phys, retire_phys;
    logic        o_ready, o_valid, o_uses_rs, o_uses_rt, o_uses_rw;
    logic [5:0]  o_rs_phys, o_rt_phys, o_rw_phys, o_old_rw_phys;
    logic [63:0] o_busy_bits;
    logic [6:0]  o_free_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int       map_m [32];
    int       fl_m [$];
    int       rq_m [$];
    bit [63:0] busy_m;
    int       e_valid, e_urs, e_urt, e_urw, e_rs, e_rt, e_rw, e_old;

    reg_rename dut (
        .clk(clk), .rst(rst), .i_valid(valid),
        .i_uses_rs(uses_rs), .i_uses_rt(uses_rt), .i_uses_rw(uses_rw),
        .i_rs_addr(rs_addr), .i_rt_addr(rt_addr), .i_rw_addr(rw_addr),
        .i_stall(stall), .o_ready(o_ready), .o_valid(o_valid),
        .o_uses_rs(o_uses_rs), .o_uses_rt(o_uses_rt), .o_uses_rw(o_uses_rw),
        .o_rs_phys(o_rs_phys), .o_rt_phys(o_rt_phys), .o_rw_phys(o_rw_phys),
        .o_old_rw_phys(o_old_rw_phys), .o_busy_bits(o_busy_bits),
        .i_wb_valid(wb_valid), .i_wb_phys(wb_phys),
        .i_retire_valid(retire_valid), .i_retire_old_phys(retire_phys),
        .o_free_count(o_free_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) map_m[i] = i;
        fl_m.delete();
        for (int i = 32; i < 64; i++) fl_m.push_back(i);
        rq_m.delete();
        busy_m = '0;
        {e_valid, e_urs, e_urt, e_urw, e_rs, e_rt, e_rw, e_old} = '0;
    endtask

    task automatic clear_inputs();
        valid = 0; uses_rs = 0; uses_rt = 0; uses_rw = 0; stall = 0;
        rs_addr = 0; rt_addr = 0; rw_addr = 0;
        wb_valid = 0; wb_phys = 0; retire_valid = 0; retire_phys = 0;
    endtask

    task automatic set_instr(input bit urs, input int rs, input bit urt, input int rt,
                             input bit urw, input int rw);
        valid = 1; uses_rs = urs; uses_rt = urt; uses_rw = urw;
        rs_addr = 5'(rs); rt_addr = 5'(rt); rw_addr = 5'(rw);
    endtask

    // Called just after a negedge with inputs set; returns at the following negedge.
    task automatic step();
        bit        effrw, rdy, acc;
        bit [63:0] eb;
        int        np;
        #1;
        effrw = uses_rw && (rw_addr != 0);
        rdy   = !stall && (fl_m.size() != 0 || !effrw);
        acc   = valid && rdy;
        eb    = busy_m;
`ifdef RENAME_WB_BYPASS_EN
        if (wb_valid) eb[wb_phys] = 1'b0;
`endif
        check_eq("ready", 64'(o_ready), 64'(rdy));
        check_eq("free_count", 64'(o_free_count), 64'(fl_m.size()));
        check_eq("busy", o_busy_bits, eb);
        @(posedge clk);
        if (wb_valid && wb_phys != 0) busy_m[wb_phys] = 1'b0;
        if (!stall) begin
            e_valid = acc;
            if (acc) begin
                e_urs = uses_rs; e_urt = uses_rt; e_urw = effrw;
                e_rs = map_m[rs_addr];
                e_rt = map_m[rt_addr];
                if (effrw) begin
                    np = fl_m.pop_front();
                    e_old = map_m[rw_addr];
                    e_rw = np;
                    map_m[rw_addr] = np;
                    busy_m[np] = 1'b1;
                    rq_m.push_back(e_old);
                end else begin
                    e_rw = 0; e_old = 0;
                end
            end
        end
        if (retire_valid && retire_phys != 0 && fl_m.size() < 63) fl_m.push_back(int'(retire_phys));
        #1;
        check_eq("o_valid", 64'(o_valid), 64'(e_valid));
        check_eq("o_uses_rs", 64'(o_uses_rs), 64'(e_urs));
        check_eq("o_uses_rt", 64'(o_uses_rt), 64'(e_urt));
        check_eq("o_uses_rw", 64'(o_uses_rw), 64'(e_urw));
        check_eq("o_rs_phys", 64'(o_rs_phys), 64'(e_rs));
        check_eq("o_rt_phys", 64'(o_rt_phys), 64'(e_rt));
        check_eq("o_rw_phys", 64'(o_rw_phys), 64'(e_rw));
        check_eq("o_old_rw_phys", 64'(o_old_rw_phys), 64'(e_old));
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_valid", 64'(o_valid), 64'd0);
        check_eq("rst_free", 64'(o_free_count), 64'd32);
        check_eq("rst_busy", o_busy_bits, 64'd0);
        check_eq("rst_rw_phys", 64'(o_rw_phys), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // First rename and a back-to-back dependent instruction
        set_instr(1, 3, 1, 4, 1, 5);
        step();
        check_eq("t1_rs", 64'(o_rs_phys), 64'd3);
        check_eq("t1_rt", 64'(o_rt_phys), 64'd4);
        check_eq("t1_rw", 64'(o_rw_phys), 64'd32);
        check_eq("t1_old", 64'(o_old_rw_phys), 64'd5);
        check_eq("t1_busy32", 64'(o_busy_bits[32]), 64'd1);
        check_eq("t1_free", 64'(o_free_count), 64'd31);
        set_instr(1, 5, 0, 0, 1, 5);
        step();
        check_eq("t2_rs", 64'(o_rs_phys), 64'd32);
        check_eq("t2_rw", 64'(o_rw_phys), 64'd33);
        check_eq("t2_old", 64'(o_old_rw_phys), 64'd32);

        // Drain the free list
        for (int i = 0; i < 30; i++) begin
            set_instr(0, 0, 0, 0, 1, 1 + (i % 30));
            step();
        end
        check_eq("empty_free", 64'(o_free_count), 64'd0);
        set_instr(1, 2, 0, 0, 1, 9);
        #1;
        check_eq("empty_ready", 64'(o_ready), 64'd0);
        step();
        check_eq("empty_noacc", 64'(o_valid), 64'd0);
        set_instr(1, 2, 1, 3, 0, 9);
        step();
        check_eq("norw_acc", 64'(o_valid), 64'd1);

        // Retire phys 5 into the empty list, then allocate it
        clear_inputs();
        retire_valid = 1; retire_phys = 6'd5;
        void'(rq_m.pop_front());
        step();
        clear_inputs();
        set_instr(0, 0, 0, 0, 1, 7);
        #1;
        check_eq("refill_ready", 64'(o_ready), 64'd1);
        step();
        check_eq("refill_rw", 64'(o_rw_phys), 64'd5);

        // Writeback of a busy register
        clear_inputs();
        wb_valid = 1; wb_phys = 6'd32;
        #1;
`ifdef RENAME_WB_BYPASS_EN
        check_eq("wb_same_cycle", 64'(o_busy_bits[32]), 64'd0);
`else
        check_eq("wb_same_cycle", 64'(o_busy_bits[32]), 64'd1);
`endif
        step();
        clear_inputs();
        #1;
        check_eq("wb_next_cycle", 64'(o_busy_bits[32]), 64'd0);
        @(negedge clk);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            clear_inputs();
            valid   = ($urandom % 10) < 7;
            stall   = ($urandom % 8) == 0;
            uses_rs = 1'($urandom); uses_rt = 1'($urandom); uses_rw = ($urandom % 4) != 0;
            rs_addr = ($urandom % 2) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            rt_addr = ($urandom % 2) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            rw_addr = ($urandom % 2) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            wb_valid = ($urandom % 10) < 4;
            wb_phys  = 6'($urandom_range(0, 63));
            if (rq_m.size() > 0 && ($urandom % 100) < 35) begin
                retire_valid = 1;
                retire_phys  = 6'(rq_m.pop_front());
            end else if (($urandom % 20) == 0) begin
                retire_valid = 1;
                retire_phys  = 6'd0;
            end
            step();
        end

        // Reset during a stall with 10 allocations outstanding
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        for (int i = 1; i <= 10; i++) begin
            set_instr(1, i, 0, 0, 1, i);
            step();
        end
        set_instr(1, 3, 0, 0, 1, 11);
        stall = 1;
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_valid", 64'(o_valid), 64'd0);
        check_eq("midrst_free", 64'(o_free_count), 64'd32);
        check_eq("midrst_busy", o_busy_bits, 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            set_instr(1, i, 1, 31 - i, 0, 0);
            step();
            check_eq("ident_map", 64'(o_rs_phys), 64'(i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
